pipelined_shifter: RTL and testbench
====================================

PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data width in bits (power of two, 8..128).
REQ-002 The block SHALL have local parameter SHAMT_W, equal to log2(WIDTH), meaning the shift-amount width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset: one clock, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  input operation present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 The block SHALL have port in_data  input  WIDTH  operand.
REQ-008 The block SHALL have port in_shamt  input  SHAMT_W  shift amount.
REQ-009 The block SHALL have port in_op  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 The block SHALL have port out_valid  output  1  result present.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port out_data  output  WIDTH  shifted result.

Function
REQ-013 The block SHALL be a 2-stage registered pipeline.
  - Stage 1 applies the coarse shift, in_shamt[SHAMT_W-1:SHAMT_W/2].
  - Stage 2 applies the fine shift, the remaining low bits.
REQ-014 A transfer SHALL occur on an input when in_valid && in_ready at a clk edge.
REQ-015 A transfer SHALL occur on an output when out_valid && out_ready at a clk edge.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid, with no stall.
REQ-017 Throughput SHALL be 1 operation per cycle when out_ready is held high.
REQ-018 Stage 2 SHALL advance when !s2_valid || out_ready.
REQ-019 Stage 1 SHALL advance when !s1_valid || stage-2 advance.
REQ-020 in_ready SHALL equal the stage-1 advance condition; a combinational path from out_ready is permitted.
REQ-021 out_data SHALL be driven directly from the stage-2 register.
REQ-022 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 The pipeline SHALL drop, duplicate or reorder no operation under any out_ready pattern.
REQ-024 SLL SHALL zero-fill at the LSB end.
REQ-025 SRL SHALL zero-fill at the MSB end.
REQ-026 SRA SHALL replicate the original in_data[WIDTH-1] at the MSB end, carried through both stages.
REQ-027 Shift amount 0 SHALL return in_data unchanged for every op.
REQ-028 Shift amount WIDTH-1 SHALL be fully supported; amounts never wrap or saturate beyond SHAMT_W bits.
REQ-029 Op and shamt fine bits SHALL be carried with the data into stage 2.
REQ-030 A stage holding a bubble (valid low) SHALL not change out_data.

Reset
REQ-031 On rst high at a clk edge, s1_valid and s2_valid SHALL clear to 0.
REQ-032 After reset, out_valid SHALL be 0.
REQ-033 After reset, out_data SHALL be 0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-035 Operations in flight at reset SHALL be discarded, with no output produced for them.
REQ-036 While rst is high, in_valid SHALL be ignored and no transfer SHALL occur.

Configuration
REQ-037 With macro SHIFTER_ROTATE_EN defined, op 11 SHALL perform rotate-left, with bits leaving the MSB re-entering at the LSB.
REQ-038 Without SHIFTER_ROTATE_EN, op 11 SHALL pass in_data through unshifted with normal latency and handshake, and no rotate logic SHALL be synthesised.

Verification
REQ-039 WIDTH=64: data AAAA_BBBB_CCCC_DDDD with shamt 0, 1, 2, op SLL -> outputs AAAA_BBBB_CCCC_DDDD, 5555_7777_9999_BBBA, AAAA_EEEF_3333_7774 on consecutive cycles, 2-cycle latency.
REQ-040 Same data, shamt 4: SRL -> 0AAA_ABBB_BCCC_CDDD; SRA -> FAAA_ABBB_BCCC_CDDD; SRA of 2AAA_BBBB_CCCC_DDDD -> 02AA_ABBB_BCCC_CDDD.
REQ-041 ROL shamt 4 of AAAA_BBBB_CCCC_DDDD -> AAAB_BBBC_CCCD_DDDA with SHIFTER_ROTATE_EN, and AAAA_BBBB_CCCC_DDDD without it; SLL shamt 63 of 0000_0000_0000_0001 -> 8000_0000_0000_0000.
REQ-042 Back-pressure: stream 5 ops while out_ready is held low for 4 cycles -> in_ready low once both stages are full, out_data stable, all 5 results in order after release.
REQ-043 Assert rst with 2 ops in flight -> out_valid 0 the next cycle, no stale result emitted, in_ready 1 after rst drops.

Source files
------------

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: 2-stage SLL/SRL/SRA shifter; define SHIFTER_ROTATE_EN to make op 11 rotate-left
module pipelined_shifter #(
    parameter int WIDTH = 64,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);
    localparam int FINE_W = SHAMT_W / 2;
    logic               r_s1_valid, r_s2_valid, r_s1_sign;
    logic [WIDTH-1:0]   r_s1_data, r_s2_data;
    logic [1:0]         r_s1_op;
    logic [FINE_W-1:0]  r_s1_fine;
    logic               w_s1_adv, w_s2_adv;
    logic [WIDTH-1:0]   w_s1_next, w_s2_next;
    // sign is the original operand MSB so SRA fill survives the split into two stages
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] amt,
                                                 input logic [1:0] op, input logic sign);
`ifdef SHIFTER_ROTATE_EN
        logic [WIDTH-1:0] w_rot;
        w_rot = (d << amt) | (d >> (WIDTH - 32'(amt)));
`else
        logic [WIDTH-1:0] w_rot;
        w_rot = d;
`endif
        return op == 2'b00 ? d << amt : op == 2'b11 ? w_rot : WIDTH'({{WIDTH{sign & op[1]}}, d} >> amt);
    endfunction
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv && !rst;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign w_s1_next = f_shift(in_data, {in_shamt[SHAMT_W-1:FINE_W], {FINE_W{1'b0}}}, in_op, in_data[WIDTH-1]);
    assign w_s2_next = f_shift(r_s1_data, SHAMT_W'(r_s1_fine), r_s1_op, r_s1_sign);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= w_s1_next;
                    r_s1_op   <= in_op;
                    r_s1_fine <= in_shamt[FINE_W-1:0];
                    r_s1_sign <= in_data[WIDTH-1];
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) r_s2_data <= w_s2_next;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed vectors for pipelined_shifter with WIDTH=64
module tb_pipelined_shifter;
    localparam int NV = 19;
    typedef struct {
        logic [63:0] data;
        logic [5:0]  shamt;
        logic [1:0]  op;
        logic [63:0] exp;
    } vec_t;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [63:0] in_data = '0, out_data;
    logic [5:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    vec_t        vecs[NV];
    logic [63:0] exp_q[$];
    int          cyc_q[$];
    logic [63:0] cur_exp = '0;
    int          cyc = 0, errors = 0, checks = 0, stale = 0, k = 0;
    bit          stalled = 1'b0;
    always #5 clk = ~clk;
    pipelined_shifter #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic apply(input int i);
        in_data  = vecs[i].data;
        in_shamt = vecs[i].shamt;
        in_op    = vecs[i].op;
        cur_exp  = vecs[i].exp;
    endtask
    task automatic tick();
        logic fi, fo;
        int   lat;
        fi = in_valid && in_ready && !rst;
        fo = out_valid && out_ready;
        if (fo) begin
            if (exp_q.size() == 0) begin
                stale++;
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h with no operation outstanding", out_data);
            end else begin
                check("data", out_data, exp_q.pop_front());
                lat = cyc - cyc_q.pop_front();
                if (!stalled) check("latency", lat, 2);
            end
        end
        if (fi) begin
            exp_q.push_back(cur_exp);
            cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask
    initial begin
        vecs[0]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd0,  2'b00, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[1]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd1,  2'b00, 64'h5555_7777_9999_BBBA};
        vecs[2]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd2,  2'b00, 64'hAAAA_EEEF_3333_7774};
        vecs[3]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd4,  2'b01, 64'h0AAA_ABBB_BCCC_CDDD};
        vecs[4]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd4,  2'b10, 64'hFAAA_ABBB_BCCC_CDDD};
        vecs[5]  = '{64'h2AAA_BBBB_CCCC_DDDD, 6'd4,  2'b10, 64'h02AA_ABBB_BCCC_CDDD};
`ifdef SHIFTER_ROTATE_EN
        vecs[6]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd4,  2'b11, 64'hAAAB_BBBC_CCCD_DDDA};
        vecs[15] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd32, 2'b11, 64'hCCCC_DDDD_AAAA_BBBB};
`else
        vecs[6]  = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd4,  2'b11, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[15] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd32, 2'b11, 64'hAAAA_BBBB_CCCC_DDDD};
`endif
        vecs[7]  = '{64'h0000_0000_0000_0001, 6'd63, 2'b00, 64'h8000_0000_0000_0000};
        vecs[8]  = '{64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h0000_0000_0000_0001};
        vecs[9]  = '{64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{64'h4000_0000_0000_0000, 6'd63, 2'b10, 64'h0000_0000_0000_0000};
        vecs[11] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd32, 2'b00, 64'hCCCC_DDDD_0000_0000};
        vecs[12] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd36, 2'b01, 64'h0000_0000_0AAA_ABBB};
        vecs[13] = '{64'hF000_0000_0000_0000, 6'd8,  2'b10, 64'hFFF0_0000_0000_0000};
        vecs[14] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd0,  2'b11, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[16] = '{64'hAAAA_BBBB_CCCC_DDDD, 6'd0,  2'b10, 64'hAAAA_BBBB_CCCC_DDDD};
        vecs[17] = '{64'h8000_0000_0000_0000, 6'd7,  2'b10, 64'hFF00_0000_0000_0000};
        vecs[18] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 2'b01, 64'h0000_0000_0000_0001};
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
        // back-to-back stream with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            apply(i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) tick();
        check("drain_table", exp_q.size(), 0);
        // five ops against a consumer stalled for four cycles
        stalled = 1'b1;
        k = 0;
        for (int t = 0; t < 40 && (k < 5 || exp_q.size() > 0); t++) begin
            out_ready = (t >= 4);
            in_valid = (k < 5);
            if (k < 5) apply(k);
            #1;
            if (t == 2 || t == 3) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_hold_data", out_data, exp_q[0]);
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_count", k, 5);
        check("bp_drain", exp_q.size(), 0);
        // irregular consumer over the whole table
        k = 0;
        for (int t = 0; t < 200 && (k < NV || exp_q.size() > 0); t++) begin
            out_ready = (t % 3) != 1;
            in_valid = (k < NV);
            if (k < NV) apply(k);
            #1;
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        check("toggle_count", k, NV);
        check("toggle_drain", exp_q.size(), 0);
        // reset with two operations in flight
        out_ready = 1'b0;
        for (int t = 0; t < 2; t++) begin
            apply(t + 1);
            in_valid = 1'b1;
            tick();
        end
        check("flight_valid", out_valid, 1);
        rst = 1'b1;
        apply(3);
        tick();
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, 0);
        exp_q.delete();
        cyc_q.delete();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        check("stale_outputs", stale, 0);
        stalled = 1'b0;
        apply(2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) tick();
        check("post_rst_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
